// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB).
// Ports: clk, rst (sync, active-high), stallreq_{if,id,ex,mem}_i, flush_req_i,
//   flush_pc_i in; stall_o, flush_o, new_pc_o, busy_o, stall_timeout_o,
//   stall_cycles_o out.
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if_i,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic             flush_req_i,
  input  logic [31:0]      flush_pc_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             busy_o,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int RW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RW-1:0] TO_MAX  = RW'(STALL_TIMEOUT);
  localparam logic [RW-1:0] TO_LAST = RW'(STALL_TIMEOUT - 1);
  localparam logic [3:0]    FC      = 4'(FLUSH_CYCLES);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t        state;
  logic [3:0]    flush_cnt;
  logic [RW-1:0] run_cnt;
  logic          stalled;

  // Several stages may request at once; the deepest one wins.
  always_comb begin
    stall_o = 6'b000000;
    if (state == RUN) begin
      priority case (1'b1)
        flush_req_i:    stall_o = 6'b111111;
        stallreq_mem_i: stall_o = 6'b011111;
        stallreq_ex_i:  stall_o = 6'b001111;
        stallreq_id_i:  stall_o = 6'b000111;
        stallreq_if_i:  stall_o = 6'b000011;
        default:        stall_o = 6'b000000;
      endcase
    end
  end

  assign stalled = |stall_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      flush_cnt       <= '0;
      run_cnt         <= '0;
      flush_o         <= 1'b0;
      new_pc_o        <= '0;
      busy_o          <= 1'b0;
      stall_timeout_o <= 1'b0;
      stall_cycles_o  <= '0;
    end else begin
      if (stalled) begin
        if (stall_cycles_o != '1)
          stall_cycles_o <= stall_cycles_o + 1'b1;
        if (run_cnt != TO_MAX)
          run_cnt <= run_cnt + 1'b1;
        // Flag on the edge that completes the last allowed stalled cycle.
        if (run_cnt >= TO_LAST)
          stall_timeout_o <= 1'b1;
      end else begin
        run_cnt <= '0;
      end

      case (state)
        RUN: begin
          if (flush_req_i) begin
            state     <= FLUSH;
            flush_cnt <= FC;
            flush_o   <= 1'b1;
            new_pc_o  <= flush_pc_i;
            busy_o    <= 1'b1;
          end
        end
        FLUSH: begin
          // Requests arriving here are dropped; MEM re-raises later.
          if (flush_cnt == 4'd1) begin
            state     <= RUN;
            flush_cnt <= '0;
            flush_o   <= 1'b0;
            new_pc_o  <= '0;
            busy_o    <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl against a cycle-level reference model.
// Ports: none (top-level testbench).
module tb_pipeline_ctrl;

  localparam int FLC = 2;
  localparam int STO = 8;
  localparam int CW  = 4;

  logic          clk;
  logic          rst;
  logic          rq_if, rq_id, rq_ex, rq_mem;
  logic          fl_req;
  logic [31:0]   fl_pc;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic          busy;
  logic          tmo;
  logic [CW-1:0] scnt;

  pipeline_ctrl #(
    .FLUSH_CYCLES (FLC),
    .STALL_TIMEOUT(STO),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if_i  (rq_if),
    .stallreq_id_i  (rq_id),
    .stallreq_ex_i  (rq_ex),
    .stallreq_mem_i (rq_mem),
    .flush_req_i    (fl_req),
    .flush_pc_i     (fl_pc),
    .stall_o        (stall),
    .flush_o        (flush),
    .new_pc_o       (new_pc),
    .busy_o         (busy),
    .stall_timeout_o(tmo),
    .stall_cycles_o (scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int          m_left = 0;
  logic [31:0] m_pc = '0;
  int          m_run = 0;
  int          m_scnt = 0;
  bit          m_tmo = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Deepest requesting stage k (if=1..mem=4) holds stages 0..k.
  function automatic logic [5:0] exp_stall(input logic [3:0] req,
                                           input logic fr);
    int k;
    if (m_left > 0) return 6'd0;
    if (fr) return 6'b111111;
    k = 0;
    for (int i = 0; i < 4; i++)
      if (req[i]) k = i + 1;
    if (k == 0) return 6'd0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  // req: [0]=if [1]=id [2]=ex [3]=mem. Called just after a negedge.
  task automatic step(input logic [3:0] req, input logic fr,
                      input logic [31:0] pc, input logic r);
    logic [5:0] es;
    rq_if = req[0];
    rq_id = req[1];
    rq_ex = req[2];
    rq_mem = req[3];
    fl_req = fr;
    fl_pc = pc;
    rst = r;
    #1;
    es = exp_stall(req, fr);
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(m_left > 0));
    chk("new_pc", new_pc, (m_left > 0) ? m_pc : 32'd0);
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("timeout", 32'(tmo), 32'(m_tmo));
    chk("stall_cycles", 32'(scnt), 32'(m_scnt));
    @(posedge clk);
    if (r) begin
      m_left = 0;
      m_pc = '0;
      m_run = 0;
      m_scnt = 0;
      m_tmo = 0;
    end else begin
      if (es != 0) begin
        m_scnt = (m_scnt < (1 << CW) - 1) ? m_scnt + 1 : m_scnt;
        m_run = (m_run < STO) ? m_run + 1 : m_run;
      end else begin
        m_run = 0;
      end
      if (m_run >= STO) m_tmo = 1;
      if (m_left > 0) begin
        m_left--;
      end else if (fr) begin
        m_left = FLC;
        m_pc = pc;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_rst();
    step(4'b0000, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    {rq_if, rq_id, rq_ex, rq_mem, fl_req} = '0;
    fl_pc = '0;
    @(negedge clk);
    do_rst();
    do_rst();
    idle(1);

    // EX stall for 3 cycles
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 32'd0, 1'b0);
    idle(1);
    chk("t1_cycles", 32'(scnt), 32'd3);

    // IF+ID+MEM together -> MEM wins
    step(4'b1011, 1'b0, 32'd0, 1'b0);
    idle(1);

    // Flush with MEM stall pending
    step(4'b1000, 1'b1, 32'h0000_0040, 1'b0);
    chk("t3_flush", 32'(flush), 32'd1);
    step(4'b1111, 1'b1, 32'h0000_0080, 1'b0);
    step(4'b0001, 1'b0, 32'd0, 1'b0);
    idle(2);
    chk("t3_pc_clr", new_pc, 32'd0);

    // Watchdog: 8 stalled cycles trip it, sticky after drop
    do_rst();
    for (int i = 0; i < 8; i++) step(4'b0010, 1'b0, 32'd0, 1'b0);
    idle(3);
    chk("t4_sticky", 32'(tmo), 32'd1);
    do_rst();
    for (int i = 0; i < 7; i++) step(4'b0010, 1'b0, 32'd0, 1'b0);
    idle(1);
    for (int i = 0; i < 7; i++) step(4'b0010, 1'b0, 32'd0, 1'b0);
    idle(1);
    chk("t4_no_trip", 32'(tmo), 32'd0);

    // Reset during second flush cycle, then a fresh flush
    do_rst();
    step(4'b0000, 1'b1, 32'h0000_1234, 1'b0);
    step(4'b0000, 1'b0, 32'd0, 1'b0);
    step(4'b0000, 1'b0, 32'd0, 1'b1);
    chk("t5_flush_off", 32'(flush), 32'd0);
    step(4'b0000, 1'b1, 32'h0000_5678, 1'b0);
    chk("t5_new_pc", new_pc, 32'h0000_5678);
    idle(3);

    // Counter saturation
    do_rst();
    for (int i = 0; i < 20; i++) step(4'b0100, 1'b0, 32'd0, 1'b0);
    idle(1);
    chk("t6_sat", 32'(scnt), 32'h0000_000F);

    // Random traffic
    do_rst();
    for (int i = 0; i < 500; i++) begin
      logic [3:0]  rq;
      logic        f;
      logic        r;
      rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 63) == 0);
      step(rq, f, $urandom, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
